uart_frame_assembler: RTL



---
 rtl/uart_frame_pkg.sv | 27 ++
 rtl/uart_frame_assembler_interbyte_timer.sv | 30 +++
 rtl/uart_frame_assembler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared states, frame geometry and checksum helper (UART_FRAME_CHECKSUM_EN adds a sixth byte)
package uart_frame_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      CHECK   = 3'd2,
      HOLD    = 3'd3,
      DRAIN   = 3'd4
   } state_t;

   localparam int FRAME_DATA_BYTES = 5;
`ifdef UART_FRAME_CHECKSUM_EN
   localparam int FRAME_BYTES = FRAME_DATA_BYTES + 1;
`else
   localparam int FRAME_BYTES = FRAME_DATA_BYTES;
`endif
   localparam int IDX_WIDTH = 3;

   // XOR of the control byte and the four data bytes
   function automatic logic [7:0] frame_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                                 input logic [7:0] b2, input logic [7:0] b3,
                                                 input logic [7:0] b4);
      return b0 ^ b1 ^ b2 ^ b3 ^ b4;
   endfunction

endpackage

// File: rtl/uart_frame_assembler_interbyte_timer.sv
// rtl/uart_frame_assembler_interbyte_timer.sv - saturating idle counter that flags a stalled frame
module interbyte_timer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_WIDTH-1:0] LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TIMER_WIDTH-1:0] count;

   // count idle cycles while enabled; clear wins, and the count parks at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + TIMER_WIDTH'(1);
      end
   end

   assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/uart_frame_assembler.sv
// rtl/uart_frame_assembler.sv - builds control+data frames from UART bytes (optional UART_FRAME_CHECKSUM_EN)
module uart_frame_assembler
   import uart_frame_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        masterClock,
   input  logic        reset,
   input  logic [7:0]  rxData,
   input  logic        rxValid,
   input  logic        clearDR,
   output logic        dataReceived,
   output logic [7:0]  control,
   output logic [31:0] inputData,
   output logic        overrun,
   output logic        frameError
);

   // the final byte of a frame is consumed straight from rxData, so it is never shadowed
   localparam int SHADOW_BYTES = FRAME_BYTES - 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_BYTES - 1);

   state_t               state;
   logic [IDX_WIDTH-1:0] byte_idx;
   logic [7:0]           shadow [SHADOW_BYTES];
`ifdef UART_FRAME_CHECKSUM_EN
   logic [7:0]           check_byte;
`endif

   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   assign timer_enable = (state == COLLECT);
   assign timer_clear  = rxValid || (state != COLLECT);

   interbyte_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (masterClock),
      .rst_n  (reset),
      .clear  (timer_clear),
      .enable (timer_enable),
      .expired(timer_expired)
   );

   // frame state machine with registered handshake, frame and pulse outputs
   always_ff @(posedge masterClock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         byte_idx     <= '0;
         for (int i = 0; i < SHADOW_BYTES; i++) shadow[i] <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
         check_byte   <= '0;
`endif
         dataReceived <= 1'b0;
         control      <= '0;
         inputData    <= '0;
         overrun      <= 1'b0;
         frameError   <= 1'b0;
      end else begin
         overrun    <= 1'b0;
         frameError <= 1'b0;
         case (state)
            IDLE: begin
               if (rxValid) begin
                  shadow[0] <= rxData;
                  byte_idx  <= IDX_WIDTH'(1);
                  state     <= COLLECT;
               end
            end
            COLLECT: begin
               // a byte arriving on the expiry cycle still counts, so it is tested first
               if (rxValid) begin
                  if (byte_idx == LAST_IDX) begin
                     byte_idx <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                     check_byte <= rxData;
                     state      <= CHECK;
`else
                     control      <= shadow[0];
                     inputData    <= {shadow[1], shadow[2], shadow[3], rxData};
                     dataReceived <= 1'b1;
                     state        <= HOLD;
`endif
                  end else begin
                     for (int i = 0; i < SHADOW_BYTES; i++) begin
                        if (byte_idx == IDX_WIDTH'(i)) shadow[i] <= rxData;
                     end
                     byte_idx <= byte_idx + IDX_WIDTH'(1);
                  end
               end else if (timer_expired) begin
                  frameError <= 1'b1;
                  byte_idx   <= '0;
                  state      <= IDLE;
               end
            end
            CHECK: begin
`ifdef UART_FRAME_CHECKSUM_EN
               if (rxValid) overrun <= 1'b1;
               if (frame_checksum(shadow[0], shadow[1], shadow[2], shadow[3], shadow[4]) == check_byte) begin
                  control      <= shadow[0];
                  inputData    <= {shadow[1], shadow[2], shadow[3], shadow[4]};
                  dataReceived <= 1'b1;
                  state        <= HOLD;
               end else begin
                  frameError <= 1'b1;
                  state      <= IDLE;
               end
`else
               state <= IDLE;
`endif
            end
            HOLD: begin
               if (rxValid) overrun <= 1'b1;
               if (clearDR) begin
                  dataReceived <= 1'b0;
                  state        <= DRAIN;
               end
            end
            DRAIN: begin
               // a stale acknowledge must fall before the next frame may be taken
               if (rxValid) overrun <= 1'b1;
               if (!clearDR) state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
